// File: rtl/boot_loader.sv
// Byte-stream program loader. Accepts a framed image
// (MAGIC, LEN_L, LEN_H, ADDR_L, ADDR_H, data..., CHK) on a valid/ready byte
// port, writes the data bytes into the working memory and releases the
// processor reset only after a frame whose 8-bit additive checksum matches.
module boot_loader #(
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter int         TO_W        = 20
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_LENL = 4'd1,
        S_LENH = 4'd2,
        S_ADRL = 4'd3,
        S_ADRH = 4'd4,
        S_DATA = 4'd5,
        S_CHK  = 4'd6,
        DONE   = 4'd7,
        ERR    = 4'd8
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // Running modulo-256 checksum step.
    function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [15:0]     len_r;
    logic [15:0]     addr_r;
    logic [7:0]      sum_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            mem_we_r;
    logic [15:0]     mem_addr_r;
    logic [7:0]      mem_wdata_r;
    logic            cpu_rst_r, load_done_r, load_err_r;
    logic            cpu_rst_s, load_done_s, load_err_s;
    logic            in_frame_s;
    logic            to_hit_s;
    logic            enter_lenl_s;

    // The loader never stalls the source; in_valid alone qualifies a byte.
    assign in_ready  = 1'b1;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rst   = cpu_rst_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;

    assign in_frame_s   = (state_r == S_LENL) || (state_r == S_LENH) || (state_r == S_ADRL) ||
                          (state_r == S_ADRH) || (state_r == S_DATA) || (state_r == S_CHK);
    assign to_hit_s     = in_frame_s && !in_valid && (to_cnt_r == TO_LAST);
    assign enter_lenl_s = (state_nxt_s == S_LENL) && (state_r != S_LENL);

    // State register.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: a timeout overrides everything, otherwise advance on accepted bytes.
    always_comb begin
        state_nxt_s = state_r;
        if (to_hit_s) begin
            state_nxt_s = ERR;
        end else if (in_valid) begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (in_data == MAGIC) begin
                        state_nxt_s = S_LENL;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_LENL: state_nxt_s = S_LENH;
                S_LENH: state_nxt_s = S_ADRL;
                S_ADRL: state_nxt_s = S_ADRH;
                S_ADRH: begin
                    if (len_r == 16'd0) begin
                        state_nxt_s = S_CHK;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end
                S_DATA: begin
                    if (len_r == 16'd1) begin
                        state_nxt_s = S_CHK;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end
                S_CHK: begin
                    if (in_data == sum_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Status decode from the state being entered; registered below so it lands one cycle after the deciding byte.
    always_comb begin
        cpu_rst_s   = (state_nxt_s != DONE);
        load_done_s = (state_nxt_s == DONE);
        load_err_s  = (state_nxt_s == ERR);
    end

    // Status registers.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            cpu_rst_r   <= cpu_rst_s;
            load_done_r <= load_done_s;
            load_err_r  <= load_err_s;
        end
    end

    // Inter-byte idle counter, active only while a frame is in progress.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if (!in_frame_s || in_valid || to_hit_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Frame header capture, address/length stepping and checksum accumulation.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            len_r  <= 16'h0000;
            addr_r <= 16'h0000;
            sum_r  <= 8'h00;
        end else begin
            if (enter_lenl_s) begin
                sum_r <= 8'h00;
            end else if (in_valid && (state_r == S_DATA)) begin
                sum_r <= sum8_add(sum_r, in_data);
            end
            if (in_valid) begin
                case (state_r)
                    S_LENL: len_r[7:0]   <= in_data;
                    S_LENH: len_r[15:8]  <= in_data;
                    S_ADRL: addr_r[7:0]  <= in_data;
                    S_ADRH: addr_r[15:8] <= in_data;
                    S_DATA: begin
                        addr_r <= addr_r + 16'd1;
                        len_r  <= len_r - 16'd1;
                    end
                    default: begin
                        len_r  <= len_r;
                        addr_r <= addr_r;
                    end
                endcase
            end
        end
    end

    // Memory write port: one strobe per accepted data byte, address/data held between writes.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 8'h00;
        end else if (in_valid && (state_r == S_DATA)) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= in_data;
        end else begin
            mem_we_r    <= 1'b0;
        end
    end

endmodule
